irq_sink_ctrl: RTL and testbench

//  Receiving end of the single-bit `intr` lines that sub-blocks raise toward their parent.

---
 rtl/irq_sink_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_sink_ctrl.sv | 105 ++++++++++
 tb/tb_irq_sink_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/irq_sink_pkg.sv
// rtl/irq_sink_pkg.sv - shared defaults, FSM state type and ID width helper for the interrupt sink
package irq_sink_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc
  import irq_sink_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEF,
  localparam int ID_W    = id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // scan from the top down so the lowest set index is the last assignment and wins
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_sink_ctrl.sv
// rtl/irq_sink_ctrl.sv - edge-latched, masked, prioritised interrupt sink with valid/ready ID port
module irq_sink_ctrl
  import irq_sink_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int ID_W    = id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] intr_in,
  input  logic [NUM_SRC-1:0] mask_in,
  output logic               irq_valid,
  input  logic               irq_ready,
  output logic [ID_W-1:0]    irq_id,
  output logic               intr,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_vec;
  logic               win_any;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               drop_now;
  state_t             state;
  state_t             state_next;

  assign rise     = intr_in & ~prev;
  assign eligible = pending & mask_in;
  assign accept   = irq_valid & irq_ready;
  assign drop_now = |(rise & pending & ~clr_vec);
  assign irq_id   = id_q;
  assign drop_cnt = cnt_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .vec (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  // previous line levels track the inputs even in reset, so a line held high across reset is no event
  always_ff @(posedge clk) begin
    prev <= intr_in;
  end

  // one-hot clear of the accepted source
  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[id_q] = 1'b1;
  end

  // pending latch: a new edge overrides a same-cycle acceptance clear
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | rise;
  end

  // saturating count of edges that hit an already-pending source; one count per cycle at most
  always_ff @(posedge clk) begin
    if (rst)                                    cnt_q <= '0;
    else if (drop_now && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
  end

  // aggregate upward interrupt from the pre-update pending vector
  always_ff @(posedge clk) begin
    if (rst) intr <= 1'b0;
    else     intr <= |eligible;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: offer when anything is eligible, leave only on handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_any)   state_next = OFFER;
      OFFER:   if (irq_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: valid for as long as the offer stands
  always_comb begin
    irq_valid = (state == OFFER);
  end

  // offered ID captured on entry to OFFER and frozen until accepted
  always_ff @(posedge clk) begin
    if (rst)                         id_q <= '0;
    else if (state == IDLE && win_any) id_q <= win_idx;
  end

endmodule

// File: tb/tb_irq_sink_ctrl.sv
// tb/tb_irq_sink_ctrl.sv - directed self-checking bench with an expected-ID scoreboard
module tb_irq_sink_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] intr_in;
  logic [3:0] mask_in;
  logic       irq_valid;
  logic       irq_ready;
  logic [1:0] irq_id;
  logic       intr;
  logic [7:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  irq_sink_ctrl #(
    .NUM_SRC (4),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .intr_in   (intr_in),
    .mask_in   (mask_in),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_id    (irq_id),
    .intr      (intr),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // scoreboard: every accepted ID must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && irq_valid && irq_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed id %0d expected none", irq_id);
      end
      if (exp_q.size() != 0) check("sb_id", irq_id, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; intr_in = '0; mask_in = '0; irq_ready = 1'b0;
    repeat (3) tick();
    sample();
    check("rst_valid", irq_valid, 0);
    check("rst_id",    irq_id,    0);
    check("rst_intr",  intr,      0);
    check("rst_drop",  drop_cnt,  0);
    tick(); rst = 1'b0;

    // 1: single event on source 2, ready held high
    mask_in = 4'hF; irq_ready = 1'b1;
    tick(); intr_in[2] = 1'b1; exp_q.push_back(2);
    sample(); check("t1_c0_valid", irq_valid, 0);
    tick(); intr_in[2] = 1'b0;
    sample(); check("t1_c1_valid", irq_valid, 0); check("t1_c1_intr", intr, 0);
    tick(); sample();
    check("t1_c2_valid", irq_valid, 1); check("t1_c2_id", irq_id, 2); check("t1_c2_intr", intr, 1);
    tick(); sample(); check("t1_c3_valid", irq_valid, 0); check("t1_c3_intr", intr, 1);
    tick(); sample(); check("t1_c4_valid", irq_valid, 0); check("t1_c4_intr", intr, 0);

    // 2: simultaneous edges on 3 and 1, lowest index first
    tick(); intr_in = 4'b1010; exp_q.push_back(1); exp_q.push_back(3);
    tick(); intr_in = 4'b0000;
    sample(); check("t2_c1_valid", irq_valid, 0);
    tick(); sample(); check("t2_c2_valid", irq_valid, 1); check("t2_c2_id", irq_id, 1);
    tick(); sample(); check("t2_c3_valid", irq_valid, 0);
    tick(); sample(); check("t2_c4_valid", irq_valid, 1); check("t2_c4_id", irq_id, 3);
    tick(); sample(); check("t2_c5_valid", irq_valid, 0); check("t2_drop", drop_cnt, 0);

    // 3: source 0 masked, backpressure on source 2
    tick(); mask_in = 4'b1110; irq_ready = 1'b0; intr_in = 4'b0101; exp_q.push_back(2);
    tick(); intr_in = 4'b0000;
    tick(); sample(); check("t3_offer_valid", irq_valid, 1); check("t3_offer_id", irq_id, 2);
    for (int i = 0; i < 10; i++) begin
      tick(); sample();
      check("t3_hold_valid", irq_valid, 1);
      check("t3_hold_id", irq_id, 2);
    end
    tick(); irq_ready = 1'b1;
    sample(); check("t3_acc_valid", irq_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      check("t3_no_id0", irq_valid, 0);
      if (i >= 1) check("t3_intr_masked", intr, 0);
    end
    tick(); mask_in = 4'hF; exp_q.push_back(0);
    sample(); check("t3_unmask_c0", irq_valid, 0);
    tick(); sample(); check("t3_id0_valid", irq_valid, 1); check("t3_id0", irq_id, 0);
    tick(); sample(); check("t3_after_valid", irq_valid, 0);

    // 5: new edge on source 2 in its own acceptance cycle
    tick(); irq_ready = 1'b0; intr_in[2] = 1'b1; exp_q.push_back(2);
    tick(); intr_in = 4'b0000;
    tick(); sample(); check("t5_offer_valid", irq_valid, 1); check("t5_offer_id", irq_id, 2);
    tick(); sample(); check("t5_wait_valid", irq_valid, 1);
    tick(); irq_ready = 1'b1; intr_in[2] = 1'b1; exp_q.push_back(2);
    sample(); check("t5_acc_valid", irq_valid, 1); check("t5_acc_id", irq_id, 2);
    tick(); intr_in = 4'b0000;
    sample(); check("t5_gap_valid", irq_valid, 0);
    tick(); sample(); check("t5_reoffer_valid", irq_valid, 1); check("t5_reoffer_id", irq_id, 2);
    tick(); sample(); check("t5_drop", drop_cnt, 0);

    // 4: 300 edges on a pending, unacknowledged source 1
    tick(); irq_ready = 1'b0; intr_in[1] = 1'b1; exp_q.push_back(1);
    tick(); intr_in = 4'b0000;
    tick(); sample(); check("t4_offer_id", irq_id, 1);
    for (int i = 0; i < 300; i++) begin
      tick(); intr_in[1] = 1'b1;
      tick(); intr_in[1] = 1'b0;
      if (i == 9 || i == 254) begin
        sample();
        check("t4_drop_mid", drop_cnt, i + 1);
      end
    end
    tick(); sample();
    check("t4_drop_sat", drop_cnt, 255);
    check("t4_still_valid", irq_valid, 1);
    check("t4_still_id", irq_id, 1);
    tick(); irq_ready = 1'b1;
    tick(); sample(); check("t4_acc_done", irq_valid, 0); check("t4_drop_hold", drop_cnt, 255);

    // 6: line held high through reset, then reset mid-offer
    tick(); rst = 1'b1; intr_in[0] = 1'b1; irq_ready = 1'b0;
    tick(); tick(); sample(); check("t6_rst_drop", drop_cnt, 0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); sample();
      check("t6_no_evt_valid", irq_valid, 0);
      check("t6_no_evt_intr", intr, 0);
    end
    tick(); intr_in = 4'b1000;
    tick(); intr_in = 4'b0000;
    tick(); sample(); check("t6_offer_valid", irq_valid, 1); check("t6_offer_id", irq_id, 3);
    tick(); intr_in[3] = 1'b1;
    tick(); intr_in = 4'b0000;
    sample(); check("t6_drop_one", drop_cnt, 1); check("t6_intr", intr, 1);
    tick(); rst = 1'b1;
    tick(); sample();
    check("t6_mid_valid", irq_valid, 0);
    check("t6_mid_id",    irq_id,    0);
    check("t6_mid_intr",  intr,      0);
    check("t6_mid_drop",  drop_cnt,  0);
    tick(); rst = 1'b0;
    repeat (3) tick();
    sample(); check("t6_lost_valid", irq_valid, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
